tc_acc_buffer: RTL

//  Accumulation stage directly downstream of the tensor-core reduction network.
//  Per accepted beat it takes N_ADT signed DW_DATA partial sums, one per row.
//  It sign-extends them and accumulates each over K_STEPS beats into a DW_ACC register.
//  It then presents the finished N_ADT-wide result on a valid/ready output register for writeback.

---
 rtl/tc_acc_buffer.sv | 77 +++++++
 1 files changed

// File: rtl/tc_acc_buffer.sv
// Accumulation stage behind the tensor-core reduction network: sums K_STEPS beats
// of N_ADT signed partial sums per lane and holds each finished result on a valid/ready register.
module tc_acc_buffer #(
  parameter  int unsigned N_ADT   = 4,
  parameter  int unsigned DW_DATA = 8,
  parameter  int unsigned DW_ACC  = 24,
  parameter  int unsigned K_STEPS = 4,
  localparam int unsigned DW_CNT  = $clog2(K_STEPS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_ADT*DW_DATA-1:0]  in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_ADT*DW_ACC-1:0]   out,
  output logic [DW_CNT-1:0]         k_cnt
);

  logic [N_ADT*DW_ACC-1:0] r_acc;
  logic [N_ADT*DW_ACC-1:0] r_out;
  logic                    r_out_valid;
  logic [DW_CNT-1:0]       r_k_cnt;

  logic [N_ADT*DW_ACC-1:0] w_sum;
  logic signed [DW_DATA-1:0] w_lane [N_ADT];
  logic                    w_last;
  logic                    w_accept;
  logic                    w_pop;

  // Per-lane sign-extend and add; wraps modulo 2^DW_ACC.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < N_ADT; i++) begin
      w_lane[i] = in[i*DW_DATA +: DW_DATA];
      w_sum[i*DW_ACC +: DW_ACC] = r_acc[i*DW_ACC +: DW_ACC] + DW_ACC'(w_lane[i]);
    end
  end

  // Only a final beat can be blocked, and only by an unpopped result.
  assign w_last   = (r_k_cnt == DW_CNT'(K_STEPS - 1));
  assign in_ready = !w_last || !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_pop    = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_k_cnt     <= '0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_acc   <= '0;
          r_k_cnt <= '0;
        end else begin
          r_acc   <= w_sum;
          r_k_cnt <= r_k_cnt + DW_CNT'(1);
        end
      end
      // A final accept overrides a same-cycle pop so results stream without bubbles.
      if (w_accept && w_last) begin
        r_out       <= w_sum;
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign k_cnt     = r_k_cnt;

endmodule
